spi_reg_writer: RTL and testbench



---
 rtl/reg_map_pkg.sv | 45 ++++
 rtl/spi_sync_edge.sv | 57 +++++
 rtl/spi_reg_writer.sv | 193 +++++++++++++++++++
 tb/tb_spi_reg_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_map_pkg.sv
// Shared register-map definitions for the SPI register writer and reg_map:
// address constants, command bit positions, FSM encoding and address helpers.
package reg_map_pkg;

    localparam int NUM_REGS = 31;

    // Each band gain is 24 bits wide, stored LSB first in three consecutive bytes
    localparam int GAIN_BYTES = 3;

    localparam logic [6:0] CFG        = 7'd0;
    localparam logic [6:0] GAIN1_LSB  = 7'd1;
    localparam logic [6:0] GAIN1_MID  = 7'd2;
    localparam logic [6:0] GAIN1_MSB  = 7'd3;
    localparam logic [6:0] GAIN10_LSB = 7'd28;
    localparam logic [6:0] GAIN10_MID = 7'd29;
    localparam logic [6:0] GAIN10_MSB = 7'd30;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CMD     = 2'd1;
    localparam state_t ST_DATA    = 2'd2;
    localparam state_t ST_DISCARD = 2'd3;
    localparam state_t ST_READ    = 2'd3;

    function automatic logic [6:0] gain_lsb(input int band);
        return 7'(GAIN1_LSB + GAIN_BYTES * (band - 1));
    endfunction

    function automatic logic addr_valid(input logic [6:0] a, input int nregs);
        return int'(a) < nregs;
    endfunction

    // Wraps at the end of the register map, and naturally at 127 for out-of-range starts
    function automatic logic [6:0] next_addr(input logic [6:0] a, input int nregs);
        if (int'(a) == nregs - 1) begin
            return 7'd0;
        end else begin
            return a + 7'd1;
        end
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus registered SCLK edge pulses and
// chip-select edge flags that stay quiet until the sync chain holds real samples.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic mosi_o,
    output logic cs_n_o,
    output logic cs_rise_o,
    output logic cs_fall_o
);

    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic       sclk_rise_q;
    logic       sclk_fall_q;
    logic       mosi_smp_q;
    logic [1:0] prime_q;
    logic       primed_s;

    // Sync chains, edge registers and post-reset priming counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= 3'b000;
            cs_q        <= 3'b111;
            mosi_q      <= 2'b00;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            mosi_smp_q  <= 1'b0;
            prime_q     <= 2'd0;
        end else begin
            sclk_q      <= {sclk_q[1:0], sclk_i};
            cs_q        <= {cs_q[1:0], cs_n_i};
            mosi_q      <= {mosi_q[0], mosi_i};
            sclk_rise_q <= sclk_q[1] & ~sclk_q[2];
            sclk_fall_q <= ~sclk_q[1] & sclk_q[2];
            mosi_smp_q  <= mosi_q[1];
            prime_q     <= (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
        end
    end

    // A CS edge only counts once both compared stages hold real pin samples,
    // so a reset in the middle of a frame never looks like a fresh CS fall.
    assign primed_s    = (prime_q == 2'd3);
    assign cs_rise_o   = primed_s & cs_q[1] & ~cs_q[2];
    assign cs_fall_o   = primed_s & ~cs_q[1] & cs_q[2];
    assign cs_n_o      = cs_q[1];
    assign sclk_rise_o = sclk_rise_q;
    assign sclk_fall_o = sclk_fall_q;
    assign mosi_o      = mosi_smp_q;

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 slave that turns host frames into one-cycle byte writes for reg_map.
// Optional read frames are enabled by defining SPI_READBACK_EN.
module spi_reg_writer
    import reg_map_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int NUM_REGS   = reg_map_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            data_in,
    output logic                  busy,
    output logic                  frame_err
`ifdef SPI_READBACK_EN
    ,
    input  logic [7:0]            rd_data,
    output logic                  spi_miso
`endif
);

    logic sclk_rise_s, sclk_fall_s, mosi_s, cs_n_s, cs_rise_s, cs_fall_s;

    spi_sync_edge u_sync (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (spi_sclk),
        .cs_n_i      (spi_cs_n),
        .mosi_i      (spi_mosi),
        .sclk_rise_o (sclk_rise_s),
        .sclk_fall_o (sclk_fall_s),
        .mosi_o      (mosi_s),
        .cs_n_o      (cs_n_s),
        .cs_rise_o   (cs_rise_s),
        .cs_fall_o   (cs_fall_s)
    );

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            shift_q, shift_d;
    logic [6:0]            cur_addr_q, cur_addr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            byte_s;
    logic [6:0]            next_s;

`ifdef SPI_READBACK_EN
    logic [7:0] miso_shift_q, miso_shift_d;
    logic       miso_q, miso_d;
    logic       load_q, load_d;
`else
    logic       unused_fall_s;
    assign unused_fall_s = sclk_fall_s;
`endif

    assign byte_s = {shift_q, mosi_s};
    assign next_s = next_addr(cur_addr_q, NUM_REGS);

    // Frame FSM, bit counter and write-port next state
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cur_addr_d  = cur_addr_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
`ifdef SPI_READBACK_EN
        miso_shift_d = miso_shift_q;
        miso_d       = miso_q;
        load_d       = 1'b0;
`endif
        if (cs_rise_s) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            frame_err_d = (state_q != ST_IDLE) && (bit_cnt_q != 3'd0);
        end else if (cs_fall_s) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
        end else if (sclk_rise_s && (state_q != ST_IDLE)) begin
            shift_d   = byte_s[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        cur_addr_d = byte_s[CMD_ADDR_MSB:0];
                        if (byte_s[CMD_RW_BIT] == 1'b0) begin
                            state_d = ST_DATA;
                        end else begin
`ifdef SPI_READBACK_EN
                            state_d = ST_READ;
                            addr_d  = {{(ADDR_WIDTH-7){1'b0}}, byte_s[CMD_ADDR_MSB:0]};
                            load_d  = 1'b1;
`else
                            state_d = ST_DISCARD;
`endif
                        end
                    end
                    ST_DATA: begin
                        if (addr_valid(cur_addr_q, NUM_REGS)) begin
                            we_d   = 1'b1;
                            addr_d = {{(ADDR_WIDTH-7){1'b0}}, cur_addr_q};
                            data_d = byte_s;
                        end else begin
                            we_d = 1'b0;
                        end
                        cur_addr_d = next_s;
                    end
                    ST_DISCARD: begin
`ifdef SPI_READBACK_EN
                        cur_addr_d = next_s;
                        addr_d     = {{(ADDR_WIDTH-7){1'b0}}, next_s};
                        load_d     = 1'b1;
`else
                        cur_addr_d = cur_addr_q;
`endif
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                cur_addr_d = cur_addr_q;
            end
        end else begin
            state_d = state_q;
        end
`ifdef SPI_READBACK_EN
        // Read data is captured the cycle after addr settles, then shifted out on SCLK falls
        if (load_q) begin
            miso_shift_d = addr_valid(cur_addr_q, NUM_REGS) ? rd_data : 8'h00;
        end else if (sclk_fall_s && (state_q == ST_READ)) begin
            miso_d       = miso_shift_q[7];
            miso_shift_d = {miso_shift_q[6:0], 1'b0};
        end else begin
            miso_shift_d = miso_shift_q;
        end
        if (state_d != ST_READ) begin
            miso_d = 1'b0;
        end else begin
            miso_d = miso_d;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            cur_addr_q  <= 7'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= 8'h00;
            frame_err_q <= 1'b0;
`ifdef SPI_READBACK_EN
            miso_shift_q <= 8'h00;
            miso_q       <= 1'b0;
            load_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cur_addr_q  <= cur_addr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_READBACK_EN
            miso_shift_q <= miso_shift_d;
            miso_q       <= miso_d;
            load_q       <= load_d;
`endif
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign data_in   = data_q;
    assign frame_err = frame_err_q;
    assign busy      = ~cs_n_s;
`ifdef SPI_READBACK_EN
    assign spi_miso  = miso_q;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: drives SPI frames from a linear script and
// checks writes, latencies, error pulses and reset behaviour against fixed values.
module tb_spi_reg_writer;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst, spi_sclk, spi_cs_n, spi_mosi;
    logic        we, busy, frame_err;
    logic [30:0] addr;
    logic [7:0]  data_in;
`ifdef SPI_READBACK_EN
    logic [7:0]  rd_data;
    logic        spi_miso;
    assign rd_data = addr[7:0] + 8'h40;
`endif

    int vectors = 0;
    int miscompares = 0;
    int n_ferr = 0;
    logic [30:0] wa_q[$];
    logic [7:0]  wd_q[$];

    always #5 clk = ~clk;

    spi_reg_writer dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .we        (we),
        .addr      (addr),
        .data_in   (data_in),
        .busy      (busy),
        .frame_err (frame_err)
`ifdef SPI_READBACK_EN
        ,
        .rd_data   (rd_data),
        .spi_miso  (spi_miso)
`endif
    );

    // Write and error-pulse logger
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(addr);
            wd_q.push_back(data_in);
        end
        if (frame_err === 1'b1) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits, input bit chk_lat,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = b[i];
            repeat (HALF) @(negedge clk);
`ifdef SPI_READBACK_EN
            rx[i] = spi_miso;
`endif
            spi_sclk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (chk_lat && i == 0) check("we_latency", {31'd0, we}, {31'd0, k == 4});
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] rx;
        spi_byte(b, 8, 1'b0, rx);
    endtask

    task automatic cs_low(input bit chk);
        spi_cs_n = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (chk && k <= 3) check("busy_latency", {31'd0, busy}, {31'd0, k >= 2});
        end
    endtask

    task automatic cs_high(input bit chk_err);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (chk_err && k <= 4) check("ferr_latency", {31'd0, frame_err}, {31'd0, k == 3});
        end
    endtask

    task automatic expect_wr(input string tag, input logic [30:0] a, input logic [7:0] d);
        if (wa_q.size() != 0) begin
            check({tag, "_addr"}, {1'b0, wa_q.pop_front()}, {1'b0, a});
            check({tag, "_data"}, {24'd0, wd_q.pop_front()}, {24'd0, d});
        end
    endtask

    initial begin
        logic [7:0] rx;
        int ferr_base;
        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_addr", {1'b0, addr}, 32'd0);
        check("rst_data", {24'd0, data_in}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single write with latency checks
        ferr_base = n_ferr;
        cs_low(1'b1);
        send(8'h00);
        check("busy_mid", {31'd0, busy}, 32'd1);
        spi_byte(8'hAA, 8, 1'b1, rx);
        cs_high(1'b0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("t1_count", wa_q.size(), 32'd1);
        expect_wr("t1", 31'd0, 8'hAA);
        check("t1_ferr", n_ferr - ferr_base, 32'd0);

        // Burst into GAIN1 bytes
        cs_low(1'b0);
        send(8'h01); send(8'hA0); send(8'hFE); send(8'hFF);
        cs_high(1'b0);
        check("t2_count", wa_q.size(), 32'd3);
        expect_wr("t2_w0", 31'd1, 8'hA0);
        expect_wr("t2_w1", 31'd2, 8'hFE);
        expect_wr("t2_w2", 31'd3, 8'hFF);
        check("t2_hold_addr", {1'b0, addr}, 32'd3);
        check("t2_hold_data", {24'd0, data_in}, 32'hFF);

        // Wrap from the last register back to CFG
        cs_low(1'b0);
        send(8'h1D); send(8'h15); send(8'h00); send(8'h77);
        cs_high(1'b0);
        check("t3_count", wa_q.size(), 32'd3);
        expect_wr("t3_w0", 31'd29, 8'h15);
        expect_wr("t3_w1", 31'd30, 8'h00);
        expect_wr("t3_w2", 31'd0, 8'h77);

        // Out-of-range start consumes the byte silently
        cs_low(1'b0);
        send(8'h7F); send(8'h55);
        cs_high(1'b0);
        check("t4_oor_count", wa_q.size(), 32'd0);
        cs_low(1'b0);
        send(8'h00); send(8'h11);
        cs_high(1'b0);
        check("t4_count", wa_q.size(), 32'd1);
        expect_wr("t4", 31'd0, 8'h11);

        // Partial data byte then CS rise
        ferr_base = n_ferr;
        cs_low(1'b0);
        send(8'h00);
        spi_byte(8'hC8, 5, 1'b0, rx);
        cs_high(1'b1);
        check("t5_count", wa_q.size(), 32'd0);
        check("t5_ferr", n_ferr - ferr_base, 32'd1);

        // Reset in the middle of a byte
        ferr_base = n_ferr;
        cs_low(1'b0);
        send(8'h0A); send(8'h99);
        check("t5b_count", wa_q.size(), 32'd1);
        expect_wr("t5b", 31'd10, 8'h99);
        spi_byte(8'hF0, 3, 1'b0, rx);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_we", {31'd0, we}, 32'd0);
        check("mid_rst_addr", {1'b0, addr}, 32'd0);
        check("mid_rst_data", {24'd0, data_in}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        spi_byte(8'hF0, 5, 1'b0, rx);
        send(8'hEE);
        cs_high(1'b0);
        check("t5b_ignored", wa_q.size(), 32'd0);
        check("t5b_ferr", n_ferr - ferr_base, 32'd0);
        cs_low(1'b0);
        send(8'h05); send(8'h3C);
        cs_high(1'b0);
        check("t5c_count", wa_q.size(), 32'd1);
        expect_wr("t5c", 31'd5, 8'h3C);

`ifdef SPI_READBACK_EN
        // Read frame starting at GAIN1_MSB
        begin
            logic [7:0] rx1, rx2;
            cs_low(1'b0);
            send(8'h83);
            spi_byte(8'h00, 8, 1'b0, rx1);
            spi_byte(8'h00, 8, 1'b0, rx2);
            cs_high(1'b0);
            check("t6_rx0", {24'd0, rx1}, 32'h43);
            check("t6_rx1", {24'd0, rx2}, 32'h44);
            check("t6_count", wa_q.size(), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
